// File: rtl/cell_plotter.sv
// rtl/cell_plotter.sv - Connect-4 pixel-fill engine: one draw request in, one pixel per clock out
module cell_plotter #(
    parameter int X_ORIGIN = 25,
    parameter int Y_ORIGIN = 10,
    parameter int CELL     = 15,
    parameter int PITCH    = 16,
    parameter int COLS     = 7,
    parameter int ROWS     = 7,
    parameter int COL_W    = 3,
    parameter int ROW_W    = 3,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int CW       = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [COL_W-1:0] column,
    input  logic [ROW_W-1:0] row,
    input  logic [CW-1:0]    colour,
    input  logic [CW-1:0]    bg_colour,
    output logic             busy,
    output logic             done,
    output logic             plot,
    output logic [XW-1:0]    x,
    output logic [YW-1:0]    y,
    output logic [CW-1:0]    colour_out
);

    localparam int AXW = $clog2(X_ORIGIN + PITCH * COLS + 1);
    localparam int AYW = $clog2(Y_ORIGIN + PITCH * ROWS + 1);
    localparam int WW  = $clog2(COLS * PITCH + 1);
    localparam int HW  = $clog2(CELL + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_FILL, S_NEXT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [COL_W-1:0] col_q, col_d, bc_q, bc_d;
    logic [ROW_W-1:0] row_q, row_d, br_q, br_d;
    logic [CW-1:0]    fg_q, fg_d, bg_q, bg_d, pcol_q, pcol_d;
    logic             seg_q, seg_d;
    logic [AXW-1:0]   base_x_q, base_x_d;
    logic [AYW-1:0]   base_y_q, base_y_d;
    logic [WW-1:0]    w_last_q, w_last_d, xo_q, xo_d;
    logic [HW-1:0]    yo_q, yo_d;
    logic             busy_q, busy_d, done_q, done_d, plot_q, plot_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;

    logic             is_cursor, is_board, out_of_range, last_rect;
    logic             load, ld_strip;
    logic [COL_W-1:0] ld_col;
    logic [ROW_W-1:0] ld_row;
    logic [CW-1:0]    ld_colour;

    assign is_cursor    = (mode_q == 2'd1);
    assign is_board     = (mode_q == 2'd2);
    assign out_of_range = (int'(col_q) >= COLS) ||
                          (!is_cursor && !is_board && int'(row_q) >= ROWS);
    assign last_rect    = is_cursor ? seg_q :
                          is_board  ? (bc_q == COL_W'(COLS - 1) && br_q == ROW_W'(ROWS - 1)) :
                                      1'b1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            mode_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            fg_q     <= '0;
            bg_q     <= '0;
            seg_q    <= 1'b0;
            bc_q     <= '0;
            br_q     <= '0;
            base_x_q <= '0;
            base_y_q <= '0;
            w_last_q <= '0;
            xo_q     <= '0;
            yo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            plot_q   <= 1'b0;
            x_q      <= XW'(X_ORIGIN);
            y_q      <= YW'(Y_ORIGIN);
            pcol_q   <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            col_q    <= col_d;
            row_q    <= row_d;
            fg_q     <= fg_d;
            bg_q     <= bg_d;
            seg_q    <= seg_d;
            bc_q     <= bc_d;
            br_q     <= br_d;
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            w_last_q <= w_last_d;
            xo_q     <= xo_d;
            yo_q     <= yo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            plot_q   <= plot_d;
            x_q      <= x_d;
            y_q      <= y_d;
            pcol_q   <= pcol_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        col_d     = col_q;
        row_d     = row_q;
        fg_d      = fg_q;
        bg_d      = bg_q;
        seg_d     = seg_q;
        bc_d      = bc_q;
        br_d      = br_q;
        base_x_d  = base_x_q;
        base_y_d  = base_y_q;
        w_last_d  = w_last_q;
        xo_d      = xo_q;
        yo_d      = yo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        plot_d    = 1'b0;
        x_d       = x_q;
        y_d       = y_q;
        pcol_d    = pcol_q;
        load      = 1'b0;
        ld_strip  = 1'b0;
        ld_col    = '0;
        ld_row    = '0;
        ld_colour = fg_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    col_d   = column;
                    row_d   = row;
                    fg_d    = colour;
                    bg_d    = bg_colour;
                    busy_d  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (out_of_range) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    load  = 1'b1;
                    seg_d = 1'b0;
                    if (is_cursor) begin
                        ld_strip  = 1'b1;
                        ld_colour = bg_q;
                    end else if (is_board) begin
                        bc_d      = '0;
                        br_d      = ROW_W'(1);
                        ld_row    = ROW_W'(1);
                        ld_colour = bg_q;
                    end else begin
                        ld_col = col_q;
                        ld_row = row_q;
                    end
                end
            end
            S_FILL: begin
                plot_d = 1'b1;
                if (xo_q == w_last_q) begin
                    xo_d = '0;
                    if (yo_q == HW'(CELL - 1)) begin
                        yo_d   = '0;
                        plot_d = 1'b0;
                        if (last_rect) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_NEXT;
                        end
                    end else begin
                        yo_d = yo_q + 1'b1;
                    end
                end else begin
                    xo_d = xo_q + 1'b1;
                end
                x_d = XW'(int'(base_x_q) + int'(xo_d));
                y_d = YW'(int'(base_y_q) + int'(yo_d));
            end
            S_NEXT: begin
                load = 1'b1;
                if (is_cursor) begin
                    seg_d  = 1'b1;
                    ld_col = col_q;
                end else begin
                    // board walk is row-major: wrap the column, then step the row
                    if (bc_q == COL_W'(COLS - 1)) begin
                        bc_d = '0;
                        br_d = br_q + 1'b1;
                    end else begin
                        bc_d = bc_q + 1'b1;
                    end
                    ld_col    = bc_d;
                    ld_row    = br_d;
                    ld_colour = bg_q;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // the first pixel of a rectangle is emitted on the same edge that loads it
        if (load) begin
            base_x_d = ld_strip ? AXW'(X_ORIGIN) : AXW'(X_ORIGIN + PITCH * int'(ld_col));
            base_y_d = AYW'(Y_ORIGIN + PITCH * int'(ld_row));
            w_last_d = ld_strip ? WW'(COLS * PITCH - 2) : WW'(CELL - 1);
            xo_d     = '0;
            yo_d     = '0;
            x_d      = XW'(int'(base_x_d));
            y_d      = YW'(int'(base_y_d));
            pcol_d   = ld_colour;
            plot_d   = 1'b1;
            state_d  = S_FILL;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign plot       = plot_q;
    assign x          = x_q;
    assign y          = y_q;
    assign colour_out = pcol_q;

endmodule
